// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL field layout, hex-to-segment table and CTRL reset value.
package seg_pkg;

  localparam logic ADDR_VALUE = 1'b0;
  localparam logic ADDR_CTRL  = 1'b1;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IMM      = 1;
  localparam int CTRL_MASK_LSB = 8;

  typedef struct packed {
    logic [7:0] mask;
    logic       imm;
    logic       en;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{mask: 8'h00, imm: 1'b0, en: 1'b1};

  // Segments packed as {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] HEX7_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to seven-segment pattern, purely combinational (zero latency).
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX7_TBL[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans two 4-digit groups in parallel; one registered output stage.
// Writes are always accepted (no backpressure); VALUE updates wait for a frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_addr,
  input  logic [31:0] wr_data,
  output logic [7:0]  digits,
  output logic [6:0]  digit_led_1,
  output logic [6:0]  digit_led_2,
  output logic        frame_tick,
  output logic        pending
);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       slot_q, slot_d;
  logic [31:0]      disp_val_q, disp_val_d;
  logic [31:0]      pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [7:0]       digits_q, digits_d;
  logic [6:0]       led1_q, led1_d;
  logic [6:0]       led2_q, led2_d;

  logic       slot_tick, frame_bnd, val_wr, ctrl_wr;
  logic       lit_lo, lit_hi;
  logic [2:0] idx_lo, idx_hi;
  logic [4:0] base_lo, base_hi;
  logic [6:0] seg_lo, seg_hi;

  always_comb begin
    slot_tick = ctrl_q.en && (presc_q == DIV_W'(CLK_DIV - 1));
    frame_bnd = slot_tick && (slot_q == 2'd3);
    val_wr    = wr_en && (wr_addr == ADDR_VALUE);
    ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
  end

  // Disabled holds the scan at slot 0 so re-enable starts a full slot.
  always_comb begin
    presc_d = presc_q + DIV_W'(1);
    slot_d  = slot_q;
    if (!ctrl_q.en) begin
      presc_d = '0;
      slot_d  = '0;
    end else if (slot_tick) begin
      presc_d = '0;
      slot_d  = slot_q + 2'd1;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.en   = wr_data[CTRL_EN];
      ctrl_d.imm  = wr_data[CTRL_IMM];
      ctrl_d.mask = wr_data[CTRL_MASK_LSB +: 8];
    end
  end

  // A write landing on the boundary cycle bypasses the buffer so it is not lost.
  always_comb begin
    disp_val_d = disp_val_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    if (val_wr) begin
      pend_val_d = wr_data;
      if (ctrl_q.imm || frame_bnd) begin
        disp_val_d = wr_data;
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (pending_q && (frame_bnd || ctrl_q.imm)) begin
      disp_val_d = pend_val_q;
      pending_d  = 1'b0;
    end
  end

  assign idx_lo  = {1'b0, slot_q};
  assign idx_hi  = {1'b1, slot_q};
  assign base_lo = {1'b0, slot_q, 2'b00};
  assign base_hi = {1'b1, slot_q, 2'b00};

  seg7_hex_decode u_dec_lo (.nib(disp_val_q[base_lo +: 4]), .seg(seg_lo));
  seg7_hex_decode u_dec_hi (.nib(disp_val_q[base_hi +: 4]), .seg(seg_hi));

  always_comb begin
    lit_lo   = ctrl_q.en && !ctrl_q.mask[idx_lo];
    lit_hi   = ctrl_q.en && !ctrl_q.mask[idx_hi];
    digits_d = '0;
    digits_d[idx_lo] = lit_lo;
    digits_d[idx_hi] = lit_hi;
    led1_d   = lit_lo ? seg_lo : 7'h00;
    led2_d   = lit_hi ? seg_hi : 7'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      slot_q     <= '0;
      disp_val_q <= '0;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      ctrl_q     <= CTRL_RST;
      digits_q   <= '0;
      led1_q     <= '0;
      led2_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      slot_q     <= slot_d;
      disp_val_q <= disp_val_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      ctrl_q     <= ctrl_d;
      digits_q   <= digits_d;
      led1_q     <= led1_d;
      led2_q     <= led2_d;
    end
  end

  assign digits      = digits_q;
  assign digit_led_1 = led1_q;
  assign digit_led_2 = led2_q;
  assign frame_tick  = frame_bnd;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4 (16-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  digits;
  logic [6:0]  digit_led_1;
  logic [6:0]  digit_led_2;
  logic        frame_tick;
  logic        pending;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .digits     (digits),
    .digit_led_1(digit_led_1),
    .digit_led_2(digit_led_2),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle write from a falling edge; returns one falling edge later.
  task automatic wr(input logic a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ftick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    chk("ftick_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_dig;
    bit seen_ft;
    bit seen_lit;

    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 1'b0;
    wr_data = '0;
    step(3);
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_led1", 32'(digit_led_1), 32'h00);
    chk("rst_led2", 32'(digit_led_2), 32'h00);
    chk("rst_ftick", 32'(frame_tick), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Free-running scan after release: 4 cycles per slot, tick every 16.
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp_dig = 8'h11 << (((k - 1) / 4) % 4);
      chk("scan_digits", 32'(digits), 32'(exp_dig));
      chk("scan_ftick", 32'(frame_tick), 32'((k % 16) == 15));
      if (k == 1) begin
        chk("scan_led1", 32'(digit_led_1), 32'h3F);
        chk("scan_led2", 32'(digit_led_2), 32'h3F);
      end
    end

    // Buffered VALUE write during slot 1.
    wr(1'b0, 32'h1234_ABCD);
    chk("buf_pending", 32'(pending), 32'h1);
    chk("buf_digits", 32'(digits), 32'h22);
    chk("buf_led1_old", 32'(digit_led_1), 32'h3F);
    wait_ftick();
    chk("buf_pending_ft", 32'(pending), 32'h1);
    chk("buf_led1_ft", 32'(digit_led_1), 32'h3F);
    step(1);
    chk("buf_pending_clr", 32'(pending), 32'h0);
    step(1);
    chk("buf_s0_digits", 32'(digits), 32'h11);
    chk("buf_s0_led1", 32'(digit_led_1), 32'h5E);
    chk("buf_s0_led2", 32'(digit_led_2), 32'h66);
    step(12);
    chk("buf_s3_digits", 32'(digits), 32'h88);
    chk("buf_s3_led1", 32'(digit_led_1), 32'h77);
    chk("buf_s3_led2", 32'(digit_led_2), 32'h06);

    // Immediate mode.
    wait_ftick();
    step(1);
    wr(1'b1, 32'h0000_0003);
    wr(1'b0, 32'hFFFF_0000);
    chk("imm_pending", 32'(pending), 32'h0);
    step(1);
    chk("imm_digits", 32'(digits), 32'h11);
    chk("imm_led1", 32'(digit_led_1), 32'h3F);
    chk("imm_led2", 32'(digit_led_2), 32'h71);

    // Write landing exactly on the frame boundary cycle.
    wr(1'b1, 32'h0000_0001);
    wait_ftick();
    wr(1'b0, 32'h0000_0009);
    chk("byp_pending", 32'(pending), 32'h0);
    step(1);
    chk("byp_digits", 32'(digits), 32'h11);
    chk("byp_led1", 32'(digit_led_1), 32'h6F);
    chk("byp_led2", 32'(digit_led_2), 32'h3F);

    // Low group blanked, high group keeps scanning.
    wr(1'b1, 32'h0000_0F01);
    wait_ftick();
    step(2);
    for (int s = 0; s < 4; s++) begin
      exp_dig = 8'h10 << s;
      chk("mask_digits", 32'(digits), 32'(exp_dig));
      chk("mask_led1", 32'(digit_led_1), 32'h00);
      chk("mask_led2", 32'(digit_led_2), 32'h3F);
      step(4);
    end

    // Disable mid-slot; a write while disabled stays pending.
    wr(1'b1, 32'h0000_0000);
    chk("dis_ftick", 32'(frame_tick), 32'h0);
    step(1);
    chk("dis_digits", 32'(digits), 32'h00);
    chk("dis_led1", 32'(digit_led_1), 32'h00);
    chk("dis_led2", 32'(digit_led_2), 32'h00);
    wr(1'b0, 32'h0000_0055);
    seen_ft  = 1'b0;
    seen_lit = 1'b0;
    repeat (20) begin
      step(1);
      if (frame_tick) seen_ft = 1'b1;
      if (digits != 8'h00) seen_lit = 1'b1;
    end
    chk("dis_no_ftick", 32'(seen_ft), 32'h0);
    chk("dis_no_lit", 32'(seen_lit), 32'h0);
    chk("dis_pending", 32'(pending), 32'h1);

    // Re-enable: slot 0 gets a full four cycles.
    wr(1'b1, 32'h0000_0001);
    chk("ren_r1_digits", 32'(digits), 32'h00);
    step(1);
    chk("ren_r2_digits", 32'(digits), 32'h11);
    chk("ren_r2_led1", 32'(digit_led_1), 32'h6F);
    step(3);
    chk("ren_r5_digits", 32'(digits), 32'h11);
    step(1);
    chk("ren_r6_digits", 32'(digits), 32'h22);

    // Switching to immediate flushes the pending value.
    wr(1'b1, 32'h0000_0003);
    step(1);
    chk("immf_pending", 32'(pending), 32'h0);
    step(1);
    chk("immf_digits", 32'(digits), 32'h22);
    chk("immf_led1", 32'(digit_led_1), 32'h6D);
    chk("immf_led2", 32'(digit_led_2), 32'h3F);

    // Reset mid-frame with a pending value.
    wr(1'b1, 32'h0000_0001);
    wr(1'b0, 32'hDEAD_BEEF);
    chk("prerst_pending", 32'(pending), 32'h1);
    chk("prerst_digits", 32'(digits), 32'h44);
    rst = 1'b0;
    #1;
    chk("arst_digits", 32'(digits), 32'h00);
    chk("arst_led1", 32'(digit_led_1), 32'h00);
    chk("arst_led2", 32'(digit_led_2), 32'h00);
    chk("arst_pending", 32'(pending), 32'h0);
    chk("arst_ftick", 32'(frame_tick), 32'h0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("post_digits", 32'(digits), 32'h11);
    chk("post_led1", 32'(digit_led_1), 32'h3F);
    chk("post_led2", 32'(digit_led_2), 32'h3F);
    chk("post_pending", 32'(pending), 32'h0);
    wait_ftick();
    step(2);
    chk("post_frame_led1", 32'(digit_led_1), 32'h3F);
    chk("post_frame_led2", 32'(digit_led_2), 32'h3F);
    chk("post_frame_pending", 32'(pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Memory-mapped scan controller for the board's 8-digit seven-segment display, replacing direct wiring of peripheral registers to the segment and enable pins.
- The CPU's data-memory peripheral decode writes a 32-bit display value and a control word.
- The block time-multiplexes two 4-digit groups in parallel: low group on digit_led_1, high group on digit_led_2.
- Value updates are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
- CLK_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.
- DIV_W, 17, prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  single-cycle write strobe from peripheral decode
- wr_addr  in  1  0 = VALUE register, 1 = CTRL register
- wr_data  in  32  write data
- digits  out  8  digit enables, active-high; [3:0] low group, [7:4] high group
- digit_led_1  out  7  segments {g,f,e,d,c,b,a}, active-high, low group
- digit_led_2  out  7  segments, high group
- frame_tick  out  1  one-cycle pulse when a frame completes (slot 3 -> 0)
- pending  out  1  VALUE write waiting for frame boundary

Behaviour:
- Reset (rst=0, asynchronous):
  - disp_val=0, pend_val=0, pending=0.
  - CTRL=0x0000_0001: enable=1, immediate=0, blank mask=0.
  - Prescaler=0, slot=0.
  - All outputs 0.
- CTRL fields:
  - bit0 enable.
  - bit1 immediate: a VALUE write loads disp_val directly.
  - bits[15:8] blank mask: bit k=1 forces digit k dark.
  - Other bits read as don't-care and are not stored.
- Prescaler (when enabled):
  - Counts 0..CLK_DIV-1; slot_tick asserts when it equals CLK_DIV-1, and it wraps to 0.
  - On slot_tick, slot (2 bits) increments and wraps 3 -> 0.
  - frame_tick pulses in the same cycle that slot wraps from 3 to 0.
- Output pipeline: one registered stage. Outputs reflect slot/disp_val/CTRL from the previous cycle.
- Digit enables: digits[slot] and digits[4+slot] = 1, except where masked.
- Segment data:
  - digit_led_1 = hex7(disp_val[4*slot+3 : 4*slot]).
  - digit_led_2 = hex7(disp_val[16+4*slot+3 : 16+4*slot]).
  - A masked digit drives enable 0 and segments 0.
- hex7 encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- VALUE write with immediate=0: pend_val <= wr_data, pending <= 1.
- Frame boundary with pending=1: disp_val <= pend_val, pending <= 0.
- VALUE write in the same cycle as the frame boundary: bypass. disp_val <= wr_data, pending <= 0.
- Successive writes within one frame: last write wins.
- VALUE write with immediate=1: disp_val <= wr_data, pend_val <= wr_data, pending <= 0.
- CTRL write: takes effect next cycle.
  - Clearing enable: prescaler and slot reset to 0; next cycle digits=0 and segments=0; frame_tick stays 0.
  - A pending value stays pending while disabled.
  - Re-enable restarts from slot 0 with a full slot period.
- Writing immediate=1 while pending=1: pending value is applied to disp_val on the next cycle.
- Reset mid-frame: all state returns to reset values immediately; no partial update survives.

Decomposition:
- Package seg_pkg holds:
  - address constants ADDR_VALUE=0, ADDR_CTRL=1;
  - CTRL bit positions (CTRL_EN=0, CTRL_IMM=1, CTRL_MASK_LSB=8);
  - the 16-entry hex7 segment constant table;
  - CTRL reset value.
- One combinational sub-module, seg7_hex_decode (4-bit nibble in -> 7-bit segments out), instantiated twice.
- Prescaler, slot counter, buffering and output registers stay in seg_scan_ctrl.

Test Plan (CLK_DIV=4, so a 16-cycle frame):
- Release reset with no writes -> at slot 0 digits=8'h11 and both segment outputs = 3F; slots advance every 4 cycles: 11, 22, 44, 88, 11; frame_tick every 16 cycles.
- Write VALUE=0x1234ABCD at slot 1 -> pending=1; display unchanged until frame_tick; then slot 0 shows digit_led_1=5E ('d'), digit_led_2=66 ('4'); slot 3 shows 77 and 06.
- Set CTRL immediate=1, write VALUE=0xFFFF0000 -> next cycle disp_val updated; digit_led_1=3F, digit_led_2=71 at the current slot; pending stays 0.
- Write VALUE=0x00000009 exactly in the frame_tick cycle -> disp_val=0x9 next cycle; pending=0; low group slot 0 shows 6F.
- CTRL=0x0000_0F01 (mask low group) -> digits[3:0] always 0 and digit_led_1=0 in masked slots; high group still scans.
- CTRL=0 mid-slot -> next cycle digits=0, segments=0, no frame_tick; re-enable -> slot 0 resumes with a full 4-cycle slot.
- Assert rst mid-frame with pending=1 -> outputs 0 and pending=0 immediately; after release the display shows 0000 0000.
